// File: rtl/cnn_conv_layer.sv
// rtl/cnn_conv_layer.sv - streaming KXxKY multi-channel convolution with bias, shift, ReLU and saturation
module cnn_conv_layer #(
  parameter int I_F_BW = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int KX     = 5,
  parameter int KY     = 5,
  parameter int CI     = 1,
  parameter int CO     = 3,
  parameter int W_BW   = 7,
  parameter int B_BW   = 7,
  parameter int O_BW   = 8,
  parameter int SH_BW  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CO*CI*KY*KX*W_BW-1:0]   i_cnn_weight,
  input  logic [CO*B_BW-1:0]            i_cnn_bias,
  input  logic                          i_relu_en,
  input  logic [SH_BW-1:0]              i_shift,
  input  logic                          i_in_valid,
  input  logic [CI*I_F_BW-1:0]          i_in_fmap,
  output logic                          o_ot_valid,
  output logic                          o_ot_last,
  output logic [CO*O_BW-1:0]            o_ot_fmap
);

  localparam int NTAP    = CI * KX * KY;
  localparam int PROD_BW = I_F_BW + W_BW + 1;
  localparam int ACC_BW  = I_F_BW + W_BW + 1 + $clog2(NTAP);
  // one spare bit so the bias add can never wrap
  localparam int SUM_BW  = ACC_BW + 1;
  localparam int COL_BW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_BW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic signed [SUM_BW-1:0] SAT_MAX = SUM_BW'((1 << (O_BW - 1)) - 1);
  localparam logic signed [SUM_BW-1:0] SAT_MIN = ~SAT_MAX;

  typedef logic [CI*I_F_BW-1:0] pix_t;

  logic [COL_BW-1:0]         r_col;
  logic [ROW_BW-1:0]         r_row;
  pix_t                      r_lb  [KY-1][IMG_W];
  pix_t                      w_col [KY];
  pix_t                      r_win [KY][KX];
  logic                      w_win_done;
  logic                      w_frame_end;
  logic                      r_s1_valid, r_s2_valid, r_s3_valid;
  logic                      r_s1_last,  r_s2_last,  r_s3_last;
  logic signed [PROD_BW-1:0] r_prod [CO][CI][KY][KX];
  logic signed [ACC_BW-1:0]  w_sum  [CO];
  logic signed [ACC_BW-1:0]  r_sum  [CO];
  logic signed [SUM_BW-1:0]  w_biased [CO];
  logic signed [SUM_BW-1:0]  w_shifted [CO];
  logic signed [SUM_BW-1:0]  w_clip [CO];
  logic [CO*O_BW-1:0]        w_res;

  // raster position of the pixel currently presented on the input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_in_valid) begin
      if (r_col == COL_BW'(IMG_W - 1)) begin
        r_col <= '0;
        if (r_row == ROW_BW'(IMG_H - 1)) r_row <= '0;
        else                             r_row <= r_row + ROW_BW'(1);
      end else begin
        r_col <= r_col + COL_BW'(1);
      end
    end
  end

  assign w_win_done  = i_in_valid && (r_row >= ROW_BW'(KY - 1)) && (r_col >= COL_BW'(KX - 1));
  assign w_frame_end = (r_row == ROW_BW'(IMG_H - 1)) && (r_col == COL_BW'(IMG_W - 1));

  // vertical column for this x: index 0 is the oldest buffered row, KY-1 is the live pixel
  always_comb begin
    for (int k = 0; k < KY - 1; k++) w_col[k] = r_lb[k][r_col];
    w_col[KY-1] = i_in_fmap;
  end

  // line buffer: every row slot at this x ages by one row, the live pixel enters the newest slot
  always_ff @(posedge clk) begin
    if (i_in_valid) begin
      for (int k = 0; k < KY - 1; k++) r_lb[k][r_col] <= w_col[k+1];
    end
  end

  // S1: window slides left by one column, new column enters at kx=KX-1
  always_ff @(posedge clk) begin
    if (i_in_valid) begin
      for (int ky = 0; ky < KY; ky++) begin
        for (int kx = 0; kx < KX - 1; kx++) r_win[ky][kx] <= r_win[ky][kx+1];
        r_win[ky][KX-1] <= w_col[ky];
      end
    end
  end

  // S2: zero-extended pixel times signed weight for every tap
  always_ff @(posedge clk) begin
    if (r_s1_valid) begin
      for (int co = 0; co < CO; co++)
        for (int ci = 0; ci < CI; ci++)
          for (int ky = 0; ky < KY; ky++)
            for (int kx = 0; kx < KX; kx++)
              r_prod[co][ci][ky][kx] <=
                PROD_BW'($signed({1'b0, r_win[ky][kx][ci*I_F_BW +: I_F_BW]})) *
                PROD_BW'($signed(i_cnn_weight[(((co*CI + ci)*KY + ky)*KX + kx)*W_BW +: W_BW]));
    end
  end

  // adder tree over all channels and taps of one output channel
  always_comb begin
    for (int co = 0; co < CO; co++) begin
      w_sum[co] = '0;
      for (int ci = 0; ci < CI; ci++)
        for (int ky = 0; ky < KY; ky++)
          for (int kx = 0; kx < KX; kx++)
            w_sum[co] = w_sum[co] + ACC_BW'(r_prod[co][ci][ky][kx]);
    end
  end

  // S3: register the window sums
  always_ff @(posedge clk) begin
    if (r_s2_valid) r_sum <= w_sum;
  end

  // bias, arithmetic shift (floor), optional ReLU, then clamp to the output range
  always_comb begin
    w_res = '0;
    for (int co = 0; co < CO; co++) begin
      w_biased[co]  = SUM_BW'(r_sum[co]) + SUM_BW'($signed(i_cnn_bias[co*B_BW +: B_BW]));
      w_shifted[co] = w_biased[co] >>> i_shift;
      w_clip[co]    = w_shifted[co];
      if (i_relu_en && w_clip[co][SUM_BW-1]) w_clip[co] = '0;
      if (w_clip[co] > SAT_MAX)      w_clip[co] = SAT_MAX;
      else if (w_clip[co] < SAT_MIN) w_clip[co] = SAT_MIN;
      w_res[co*O_BW +: O_BW] = w_clip[co][O_BW-1:0];
    end
  end

  // valid/last tokens travel alongside the data, one stage per cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s3_last  <= 1'b0;
    end else begin
      r_s1_valid <= w_win_done;
      r_s1_last  <= w_win_done && w_frame_end;
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      r_s3_valid <= r_s2_valid;
      r_s3_last  <= r_s2_last;
    end
  end

  // S4: output register, data holds between valid pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_ot_valid <= 1'b0;
      o_ot_last  <= 1'b0;
      o_ot_fmap  <= '0;
    end else begin
      o_ot_valid <= r_s3_valid;
      o_ot_last  <= r_s3_valid && r_s3_last;
      if (r_s3_valid) o_ot_fmap <= w_res;
    end
  end

endmodule

// File: tb/tb_cnn_conv_layer.sv
// tb/tb_cnn_conv_layer.sv - randomized self-checking bench for cnn_conv_layer against a window-level model
module tb_cnn_conv_layer;

  localparam int W = 28;
  localparam int H = 28;

  typedef struct {
    logic [31:0] fmap;
    logic        last;
    int          cyc;
  } rec_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [15:0]       in_fmap = '0;
  logic [524:0]      wv1 = '0;
  logic [20:0]       bv1 = '0;
  logic              relu1 = 1'b0;
  logic [3:0]        sh1 = '0;
  logic [251:0]      wv2 = '0;
  logic [13:0]       bv2 = '0;
  logic              relu2 = 1'b0;
  logic [3:0]        sh2 = '0;
  logic              v1, l1, v2, l2;
  logic [23:0]       f1;
  logic [15:0]       f2;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  rec_t q1[$];
  rec_t q2[$];
  int   expc1[$];
  int   expc2[$];

  int img [H][W][2];
  int wt  [2][3][2][5][5];
  int bs  [2][3];
  int shv [2];
  int rl  [2];

  cnn_conv_layer dut1 (
    .clk(clk), .reset(reset),
    .i_cnn_weight(wv1), .i_cnn_bias(bv1), .i_relu_en(relu1), .i_shift(sh1),
    .i_in_valid(in_valid), .i_in_fmap(in_fmap[7:0]),
    .o_ot_valid(v1), .o_ot_last(l1), .o_ot_fmap(f1)
  );

  cnn_conv_layer #(.CI(2), .CO(2), .KX(3), .KY(3)) dut2 (
    .clk(clk), .reset(reset),
    .i_cnn_weight(wv2), .i_cnn_bias(bv2), .i_relu_en(relu2), .i_shift(sh2),
    .i_in_valid(in_valid), .i_in_fmap(in_fmap),
    .o_ot_valid(v2), .o_ot_last(l2), .o_ot_fmap(f2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (v1) q1.push_back('{fmap: 32'(f1), last: l1, cyc: cyc});
    if (v2) q2.push_back('{fmap: 32'(f2), last: l2, cyc: cyc});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    q1.delete(); q2.delete(); expc1.delete(); expc2.delete();
  endtask

  task automatic apply_cfg();
    for (int co = 0; co < 3; co++) begin
      for (int ky = 0; ky < 5; ky++)
        for (int kx = 0; kx < 5; kx++)
          wv1[((co*5 + ky)*5 + kx)*7 +: 7] = 7'(wt[0][co][0][ky][kx]);
      bv1[co*7 +: 7] = 7'(bs[0][co]);
    end
    for (int co = 0; co < 2; co++) begin
      for (int ci = 0; ci < 2; ci++)
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++)
            wv2[(((co*2 + ci)*3 + ky)*3 + kx)*7 +: 7] = 7'(wt[1][co][ci][ky][kx]);
      bv2[co*7 +: 7] = 7'(bs[1][co]);
    end
    sh1 = 4'(shv[0]); relu1 = (rl[0] != 0);
    sh2 = 4'(shv[1]); relu2 = (rl[1] != 0);
  endtask

  // reference: direct convolution of the stored frame for the window whose bottom-right pixel is (r,c)
  function automatic int golden(int d, int r, int c, int co);
    int k, nci, s;
    k = (d != 0) ? 3 : 5;
    nci = (d != 0) ? 2 : 1;
    s = 0;
    for (int ci = 0; ci < nci; ci++)
      for (int ky = 0; ky < k; ky++)
        for (int kx = 0; kx < k; kx++)
          s += img[r-k+1+ky][c-k+1+kx][ci] * wt[d][co][ci][ky][kx];
    s += bs[d][co];
    s = s >>> shv[d];
    if (rl[d] != 0 && s < 0) s = 0;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  // one raster frame from img[], with random idle cycles before pixels
  task automatic drive_frame(input int gap_pct);
    int g;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        g = 0;
        while (g < 6 && $urandom_range(0, 99) < gap_pct) begin
          in_valid = 1'b0;
          step();
          g++;
        end
        in_valid = 1'b1;
        in_fmap = {8'(img[r][c][1]), 8'(img[r][c][0])};
        if (r >= 4 && c >= 4) expc1.push_back(cyc);
        if (r >= 2 && c >= 2) expc2.push_back(cyc);
        step();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    step();
    n_checks++;
    if ({v1, l1, f1} !== 26'd0) begin
      n_errors++;
      $display("FAIL reset_dut1 got v=%b l=%b f=%h exp 0", v1, l1, f1);
    end
    n_checks++;
    if ({v2, l2, f2} !== 18'd0) begin
      n_errors++;
      $display("FAIL reset_dut2 got v=%b l=%b f=%h exp 0", v2, l2, f2);
    end
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_uniform(input string name, input int pix, input int wval,
                              input int b0, input int b1, input int b2,
                              input int sh, input int relu,
                              input int e0, input int e1, input int e2);
    logic [23:0] expf;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        img[r][c][0] = pix;
        img[r][c][1] = pix;
      end
    for (int co = 0; co < 3; co++)
      for (int ky = 0; ky < 5; ky++)
        for (int kx = 0; kx < 5; kx++)
          wt[0][co][0][ky][kx] = wval;
    bs[0][0] = b0; bs[0][1] = b1; bs[0][2] = b2;
    shv[0] = sh; rl[0] = relu;
    apply_cfg();
    clear_queues();
    drive_frame(0);
    repeat (8) step();
    expf = {8'(e2), 8'(e1), 8'(e0)};
    n_checks++;
    if (q1.size() !== 576) begin
      n_errors++;
      $display("FAIL %s count got %0d exp 576", name, q1.size());
    end
    for (int i = 0; i < q1.size() && i < 576; i++) begin
      n_checks++;
      if (q1[i].fmap[23:0] !== expf) begin
        n_errors++;
        $display("FAIL %s fmap[%0d] got %h exp %h", name, i, q1[i].fmap[23:0], expf);
      end
      n_checks++;
      if (q1[i].last !== (i == 575)) begin
        n_errors++;
        $display("FAIL %s last[%0d] got %b exp %b", name, i, q1[i].last, (i == 575));
      end
      n_checks++;
      if (q1[i].cyc !== expc1[i] + 4) begin
        n_errors++;
        $display("FAIL %s latency[%0d] got cycle %0d exp %0d", name, i, q1[i].cyc, expc1[i] + 4);
      end
    end
  endtask

  task automatic test_back_to_back();
    int k;
    logic [15:0] expf;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        img[r][c][0] = (r*28 + c) % 256;
        img[r][c][1] = 255 - ((r*28 + c) % 256);
      end
    for (int co = 0; co < 2; co++) begin
      for (int ci = 0; ci < 2; ci++)
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++)
            wt[1][co][ci][ky][kx] = int'($urandom_range(0, 127)) - 64;
      bs[1][co] = int'($urandom_range(0, 127)) - 64;
    end
    shv[1] = int'($urandom_range(6, 10));
    rl[1] = int'($urandom_range(0, 1));
    apply_cfg();
    clear_queues();
    drive_frame(50);
    drive_frame(50);
    repeat (8) step();
    n_checks++;
    if (q2.size() !== 1352) begin
      n_errors++;
      $display("FAIL ramp count got %0d exp 1352", q2.size());
    end
    for (int i = 0; i < q2.size() && i < 1352; i++) begin
      k = i % 676;
      expf = {8'(golden(1, 2 + k/26, 2 + k%26, 1)), 8'(golden(1, 2 + k/26, 2 + k%26, 0))};
      n_checks++;
      if (q2[i].fmap[15:0] !== expf) begin
        n_errors++;
        $display("FAIL ramp fmap[%0d] got %h exp %h", i, q2[i].fmap[15:0], expf);
      end
      n_checks++;
      if (q2[i].last !== (k == 675)) begin
        n_errors++;
        $display("FAIL ramp last[%0d] got %b exp %b", i, q2[i].last, (k == 675));
      end
      n_checks++;
      if (q2[i].cyc !== expc2[i] + 4) begin
        n_errors++;
        $display("FAIL ramp latency[%0d] got cycle %0d exp %0d", i, q2[i].cyc, expc2[i] + 4);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [23:0] expf;
    for (int co = 0; co < 3; co++) begin
      for (int ky = 0; ky < 5; ky++)
        for (int kx = 0; kx < 5; kx++)
          wt[0][co][0][ky][kx] = int'($urandom_range(0, 127)) - 64;
      bs[0][co] = int'($urandom_range(0, 127)) - 64;
    end
    shv[0] = int'($urandom_range(8, 11));
    rl[0] = int'($urandom_range(0, 1));
    apply_cfg();
    for (int i = 0; i < 10*W + 6; i++) begin
      in_valid = 1'b1;
      in_fmap = 16'($urandom_range(0, 65535));
      step();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    n_checks++;
    if ({v1, l1, f1} !== 26'd0) begin
      n_errors++;
      $display("FAIL midreset_outputs got v=%b l=%b f=%h exp 0", v1, l1, f1);
    end
    reset = 1'b0;
    clear_queues();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        img[r][c][0] = int'($urandom_range(0, 255));
        img[r][c][1] = int'($urandom_range(0, 255));
      end
    drive_frame(30);
    repeat (8) step();
    n_checks++;
    if (q1.size() !== 576) begin
      n_errors++;
      $display("FAIL midreset count got %0d exp 576", q1.size());
    end
    for (int i = 0; i < q1.size() && i < 576; i++) begin
      expf = {8'(golden(0, 4 + i/24, 4 + i%24, 2)), 8'(golden(0, 4 + i/24, 4 + i%24, 1)),
              8'(golden(0, 4 + i/24, 4 + i%24, 0))};
      n_checks++;
      if (q1[i].fmap[23:0] !== expf) begin
        n_errors++;
        $display("FAIL midreset fmap[%0d] got %h exp %h", i, q1[i].fmap[23:0], expf);
      end
      n_checks++;
      if (q1[i].last !== (i == 575)) begin
        n_errors++;
        $display("FAIL midreset last[%0d] got %b exp %b", i, q1[i].last, (i == 575));
      end
      n_checks++;
      if (q1[i].cyc !== expc1[i] + 4) begin
        n_errors++;
        $display("FAIL midreset latency[%0d] got cycle %0d exp %0d", i, q1[i].cyc, expc1[i] + 4);
      end
    end
  endtask

  initial begin
    apply_cfg();
    test_reset();
    test_uniform("ones",         1,    1,   0,   0,   0, 0, 0,   25,   25,   25);
    test_uniform("shift2",       1,    1,   0,   0,   0, 2, 0,    6,    6,    6);
    test_uniform("bias",         1,    1,   7,  -7,   0, 0, 0,   32,   18,   25);
    test_uniform("neg_norelu",   1,   -1,   0,   0,   0, 0, 0,  -25,  -25,  -25);
    test_uniform("neg_relu",     1,   -1,   0,   0,   0, 0, 1,    0,    0,    0);
    test_uniform("sat_pos",    255,   63,  63,  63,  63, 0, 0,  127,  127,  127);
    test_uniform("sat_neg",    255,  -64, -64, -64, -64, 0, 0, -128, -128, -128);
    test_uniform("sat_neg_relu",255, -64, -64, -64, -64, 0, 1,    0,    0,    0);
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
